// File: rtl/urv_fetch_pkg.sv
// Shared definitions for the uRV instruction fetch front end:
// NOP encoding and fetch FSM state encodings.
package urv_fetch_pkg;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/urv_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode-side output and execute redirect.
// Handshake: memory accepts a request on every cycle with im_rd_o=1 and answers in request order
// with im_valid_i; decode takes f_ir_o/f_pc_o on every cycle with f_valid_o=1 and f_stall_i=0.
interface urv_fetch_if;

   logic [31:0] im_addr_o;
   logic        im_rd_o;
   logic [31:0] im_data_i;
   logic        im_valid_i;
   logic        f_stall_i;
   logic        x_bra_i;
   logic [31:0] x_bra_target_i;
   logic [31:0] f_ir_o;
   logic [31:0] f_pc_o;
   logic        f_valid_o;

   modport master (
      output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o,
      input  im_data_i, im_valid_i, f_stall_i, x_bra_i, x_bra_target_i
   );

   modport slave (
      input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o,
      output im_data_i, im_valid_i, f_stall_i, x_bra_i, x_bra_target_i
   );

endinterface

// File: rtl/urv_fetch_fifo.sv
// Small synchronous FIFO with occupancy count and flush; used for the response skid buffer
// and for the PC tags of in-flight requests.
module urv_fetch_fifo #(
   parameter int g_depth = 2,
   parameter int g_width = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [g_width-1:0]           data_i,
   output logic [g_width-1:0]           data_o,
   output logic [$clog2(g_depth+1)-1:0] count_o
);

   localparam int PW = (g_depth > 1) ? $clog2(g_depth) : 1;
   localparam int CW = $clog2(g_depth + 1);

   logic [g_width-1:0] mem [g_depth];
   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic               empty, full, do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(g_depth - 1)) ? '0 : p + PW'(1);
   endfunction

   // A push into a full FIFO is only honoured when a pop frees a slot in the same cycle.
   always_comb begin
      empty   = (count_o == '0);
      full    = (count_o == CW'(g_depth));
      do_pop  = pop_i && !flush_i && !empty;
      do_push = push_i && !flush_i && (!full || do_pop);
      data_o  = mem[rd_ptr];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_o <= '0;
      end else if (flush_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count_o <= count_o + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/urv_fetch_unit.sv
// Instruction fetch front end: issues in-order memory reads, tags responses with their PC,
// buffers them across decode stalls and discards responses made stale by a redirect.
module urv_fetch_unit
   import urv_fetch_pkg::*;
#(
   parameter logic [31:0] g_reset_vector    = 32'h0000_0000,
   parameter int          g_max_outstanding = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   urv_fetch_if.master  bus,
   output fetch_state_e state_o
);

   localparam int            CW    = $clog2(g_max_outstanding + 1);
   localparam logic [CW:0]   MAX_V = g_max_outstanding[CW:0];
   localparam logic [31:0]   RST_PC = {g_reset_vector[31:2], 2'b00};

   fetch_state_e  state, state_nxt;
   logic [31:0]   pc;
   logic [CW-1:0] outstanding, outstanding_nxt, drop, drop_nxt;
   logic [CW-1:0] skid_count, pcq_count;
   logic [CW:0]   in_use;
   logic [63:0]   skid_dout;
   logic [31:0]   pcq_dout;
   logic          issue, resp_ok, resp_dec, advance, skid_push, skid_pop, bypass;

   assign bus.im_rd_o   = issue;
   assign bus.im_addr_o = pc;
   assign state_o       = state;

   // Buffered responses count against the request budget so the skid FIFO can never overflow.
   always_comb begin
      in_use    = {1'b0, outstanding} + {1'b0, skid_count};
      issue     = (state == ST_RUN) && !bus.x_bra_i && (in_use < MAX_V);
      resp_dec  = bus.im_valid_i && (outstanding != '0);
      resp_ok   = bus.im_valid_i && !bus.x_bra_i && (drop == '0) &&
                  (state != ST_BOOT) && (pcq_count != '0);
      advance   = !bus.f_stall_i || !bus.f_valid_o;
      skid_pop  = !bus.x_bra_i && advance && (skid_count != '0);
      bypass    = !bus.x_bra_i && advance && (skid_count == '0) && resp_ok;
      skid_push = resp_ok && !bypass;

      outstanding_nxt = outstanding + CW'(issue) - CW'(resp_dec);
      if (bus.x_bra_i)
         drop_nxt = outstanding - CW'(resp_dec);
      else if ((drop != '0) && bus.im_valid_i)
         drop_nxt = drop - CW'(1);
      else
         drop_nxt = drop;

      state_nxt = state;
      case (state)
         ST_BOOT:  state_nxt = ST_RUN;
         ST_RUN:   if (bus.x_bra_i && (drop_nxt != '0)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drop_nxt == '0) state_nxt = ST_RUN;
         default:  state_nxt = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_BOOT;
         pc          <= RST_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         drop        <= drop_nxt;
         if (bus.x_bra_i)
            pc <= {bus.x_bra_target_i[31:2], 2'b00};
         else if (issue)
            pc <= pc + 32'd4;
      end
   end

   // Older buffered words always leave before a newly arrived response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.f_valid_o <= 1'b0;
         bus.f_ir_o    <= NOP_INSN;
         bus.f_pc_o    <= '0;
      end else if (bus.x_bra_i) begin
         bus.f_valid_o <= 1'b0;
      end else if (advance) begin
         if (skid_pop) begin
            {bus.f_ir_o, bus.f_pc_o} <= skid_dout;
            bus.f_valid_o            <= 1'b1;
         end else if (bypass) begin
            bus.f_ir_o    <= bus.im_data_i;
            bus.f_pc_o    <= pcq_dout;
            bus.f_valid_o <= 1'b1;
         end else begin
            bus.f_valid_o <= 1'b0;
         end
      end
   end

   urv_fetch_fifo #(.g_depth(g_max_outstanding), .g_width(32)) u_pcq (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (bus.x_bra_i),
      .push_i  (issue),
      .pop_i   (resp_ok),
      .data_i  (pc),
      .data_o  (pcq_dout),
      .count_o (pcq_count)
   );

   urv_fetch_fifo #(.g_depth(g_max_outstanding), .g_width(64)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (bus.x_bra_i),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .data_i  ({bus.im_data_i, pcq_dout}),
      .data_o  (skid_dout),
      .count_o (skid_count)
   );

endmodule

// File: tb/tb_urv_fetch_unit.sv
// Bench for urv_fetch_unit: in-order memory model with configurable latency and a golden
// PC scoreboard, directed stall/redirect/reset sequences and a long random run.
module tb_urv_fetch_unit;
   import urv_fetch_pkg::*;

   localparam logic [31:0] RST_VEC = 32'h0000_0000;
   localparam int          MAX_OUT = 2;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] tgt;
      logic        stall;
      int          lat;
      logic [31:0] exp_addr;
   } bra_vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   fetch_state_e dbg_state;
   urv_fetch_if  bus ();

   urv_fetch_unit #(.g_reset_vector(RST_VEC), .g_max_outstanding(MAX_OUT)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (bus),
      .state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   int          consumed = 0;
   int          last_due = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [31:0] mem_xor = '0;
   logic        stall_cmd = 1'b0;
   logic        bra_cmd = 1'b0;
   logic [31:0] tgt_cmd = '0;
   logic        resp_now = 1'b0;
   req_t        pend_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] gold_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ mem_xor;
   endfunction

   task automatic check(input string name, input logic ok, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic sb_fill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(gold_pc);
         gold_pc = gold_pc + 32'd4;
      end
   endtask

   task automatic sb_restart(input logic [31:0] start);
      exp_q.delete();
      gold_pc = {start[31:2], 2'b00};
      sb_fill();
   endtask

   // One clock: drive inputs on the falling edge, then observe 1 time unit later.
   task automatic cycle();
      logic [31:0] e;
      req_t        r;
      int          lat;
      @(negedge clk);
      cyc++;
      bus.f_stall_i      = stall_cmd;
      bus.x_bra_i        = bra_cmd;
      bus.x_bra_target_i = tgt_cmd;
      bus.im_valid_i     = 1'b0;
      bus.im_data_i      = $urandom();
      resp_now           = 1'b0;
      if (rst) begin
         pend_q.delete();
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         bus.im_valid_i = 1'b1;
         bus.im_data_i  = mem_word(pend_q[0].addr);
         void'(pend_q.pop_front());
         resp_now = 1'b1;
      end
      #1;
      if (!rst) begin
         if (bus.f_valid_o && !bus.f_stall_i) begin
            e = exp_q.pop_front();
            check("deliver_pc", bus.f_pc_o === e, bus.f_pc_o, e);
            check("deliver_ir", bus.f_ir_o === mem_word(e), bus.f_ir_o, mem_word(e));
            consumed++;
            sb_fill();
         end
         if (bra_cmd) begin
            check("redirect_no_issue", bus.im_rd_o === 1'b0, 32'(bus.im_rd_o), 32'd0);
            sb_restart(tgt_cmd);
         end
         if (bus.im_rd_o === 1'b1) begin
            check("addr_aligned", bus.im_addr_o[1:0] === 2'b00, bus.im_addr_o, {bus.im_addr_o[31:2], 2'b00});
            lat    = $urandom_range(lat_max, lat_min);
            r.addr = bus.im_addr_o;
            r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = r.due;
            pend_q.push_back(r);
         end
         check("outstanding_bound", pend_q.size() <= MAX_OUT, 32'(pend_q.size()), 32'(MAX_OUT));
         check("skid_no_overflow", 32'(dut.u_skid.count_o) <= MAX_OUT, 32'(dut.u_skid.count_o), 32'(MAX_OUT));
      end
   endtask

   bra_vec_t    vecs[4];
   int          first_resp, first_val, gaps, n_fly, nval, base, rd_late;
   logic        got_rd;
   logic [31:0] hold_pc, hold_ir;

   initial begin
      vecs[0] = '{tgt: 32'h0000_0100, stall: 1'b0, lat: 2, exp_addr: 32'h0000_0100};
      vecs[1] = '{tgt: 32'h0000_0203, stall: 1'b1, lat: 1, exp_addr: 32'h0000_0200};
      vecs[2] = '{tgt: 32'hFFFF_FFFC, stall: 1'b0, lat: 3, exp_addr: 32'hFFFF_FFFC};
      vecs[3] = '{tgt: 32'h0000_1001, stall: 1'b1, lat: 4, exp_addr: 32'h0000_1000};

      bus.f_stall_i = 1'b0; bus.x_bra_i = 1'b0; bus.x_bra_target_i = '0;
      bus.im_valid_i = 1'b0; bus.im_data_i = '0;
      sb_restart(RST_VEC);

      // Reset state and boot into a free-running stream with data == address.
      cycle(); cycle();
      check("rst_valid", bus.f_valid_o === 1'b0, 32'(bus.f_valid_o), 32'd0);
      check("rst_ir", bus.f_ir_o === NOP_INSN, bus.f_ir_o, NOP_INSN);
      check("rst_pc", bus.f_pc_o === 32'd0, bus.f_pc_o, 32'd0);
      check("rst_rd", bus.im_rd_o === 1'b0, 32'(bus.im_rd_o), 32'd0);
      check("rst_state", dbg_state === ST_BOOT, 32'(dbg_state), 32'(ST_BOOT));
      rst = 1'b0;
      cycle();
      check("boot_to_run", dbg_state === ST_RUN, 32'(dbg_state), 32'(ST_RUN));
      check("first_req", bus.im_rd_o === 1'b1, 32'(bus.im_rd_o), 32'd1);
      check("first_addr", bus.im_addr_o === RST_VEC, bus.im_addr_o, RST_VEC);
      first_resp = -1; first_val = -1; gaps = 0; base = consumed;
      for (int i = 0; i < 14; i++) begin
         cycle();
         if (resp_now && first_resp < 0) first_resp = cyc;
         if (bus.f_valid_o && first_val < 0) first_val = cyc;
         else if (first_val >= 0 && !bus.f_valid_o) gaps++;
      end
      check("resp_to_valid_latency", first_resp >= 0 && first_val == first_resp + 1,
            32'(first_val - first_resp), 32'd1);
      check("stream_no_gaps", gaps == 0, 32'(gaps), 32'd0);
      check("stream_count", consumed - base >= 10, 32'(consumed - base), 32'd10);

      // Asynchronous reset in the middle of the stream.
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_valid", bus.f_valid_o === 1'b0, 32'(bus.f_valid_o), 32'd0);
      check("async_rd", bus.im_rd_o === 1'b0, 32'(bus.im_rd_o), 32'd0);
      check("async_state", dbg_state === ST_BOOT, 32'(dbg_state), 32'(ST_BOOT));
      pend_q.delete();
      last_due = 0;
      mem_xor  = 32'h5A5A_0000;
      sb_restart(RST_VEC);
      cycle(); cycle();
      rst = 1'b0;
      first_val = -1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (bus.f_valid_o && first_val < 0) begin
            first_val = cyc;
            check("restart_pc", bus.f_pc_o === RST_VEC, bus.f_pc_o, RST_VEC);
         end
      end
      check("restart_seen", first_val >= 0, 32'(first_val), 32'd0);

      // Decode stall held for 5 cycles.
      for (int i = 0; i < 6; i++) cycle();
      stall_cmd = 1'b1;
      rd_late = 0;
      base = consumed;
      cycle();
      check("stall_entry_valid", bus.f_valid_o === 1'b1, 32'(bus.f_valid_o), 32'd1);
      hold_pc = bus.f_pc_o;
      hold_ir = bus.f_ir_o;
      for (int i = 1; i < 5; i++) begin
         cycle();
         check("stall_pc_hold", bus.f_pc_o === hold_pc, bus.f_pc_o, hold_pc);
         check("stall_ir_hold", bus.f_ir_o === hold_ir, bus.f_ir_o, hold_ir);
         if (i >= 2 && bus.im_rd_o) rd_late++;
      end
      check("stall_rd_stops", rd_late == 0, 32'(rd_late), 32'd0);
      stall_cmd = 1'b0;
      for (int i = 0; i < 12; i++) cycle();
      check("stall_resume", consumed - base >= 10, 32'(consumed - base), 32'd10);

      // Redirect vectors.
      foreach (vecs[k]) begin
         lat_min = vecs[k].lat;
         lat_max = vecs[k].lat;
         for (int i = 0; i < 8; i++) cycle();
         stall_cmd = vecs[k].stall;
         bra_cmd   = 1'b1;
         tgt_cmd   = vecs[k].tgt;
         cycle();
         if (vecs[k].lat == 1)
            check("redirect_coincident_resp", resp_now === 1'b1, 32'(resp_now), 32'd1);
         n_fly     = pend_q.size();
         bra_cmd   = 1'b0;
         stall_cmd = 1'b0;
         got_rd    = 1'b0;
         nval      = 0;
         for (int i = 0; i < 24; i++) begin
            cycle();
            if (i == 0) begin
               check("redirect_flush", bus.f_valid_o === 1'b0, 32'(bus.f_valid_o), 32'd0);
               check("redirect_state", dbg_state === ((n_fly != 0) ? ST_DRAIN : ST_RUN),
                     32'(dbg_state), 32'((n_fly != 0) ? ST_DRAIN : ST_RUN));
            end
            if (!got_rd && bus.im_rd_o) begin
               got_rd = 1'b1;
               check("redirect_first_addr", bus.im_addr_o === vecs[k].exp_addr,
                     bus.im_addr_o, vecs[k].exp_addr);
            end
            if (bus.f_valid_o) begin
               if (nval == 0)
                  check("redirect_first_pc", bus.f_pc_o === vecs[k].exp_addr,
                        bus.f_pc_o, vecs[k].exp_addr);
               else if (nval == 1)
                  check("redirect_second_pc", bus.f_pc_o === vecs[k].exp_addr + 32'd4,
                        bus.f_pc_o, vecs[k].exp_addr + 32'd4);
               nval++;
            end
         end
         check("redirect_resumed", nval >= 2, 32'(nval), 32'd2);
      end

      // Back-to-back redirects: the later target wins.
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 6; i++) cycle();
      bra_cmd = 1'b1; tgt_cmd = 32'h0000_0400;
      cycle();
      tgt_cmd = 32'h0000_0800;
      cycle();
      bra_cmd = 1'b0;
      first_val = -1;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (bus.f_valid_o && first_val < 0) begin
            first_val = cyc;
            check("double_redirect_pc", bus.f_pc_o === 32'h0000_0800, bus.f_pc_o, 32'h0000_0800);
         end
      end
      check("double_redirect_seen", first_val >= 0, 32'(first_val), 32'd0);

      // Random latency, stalls and redirects against the golden PC scoreboard.
      lat_min = 1; lat_max = 4;
      base = consumed;
      for (int i = 0; i < 10000; i++) begin
         stall_cmd = ($urandom_range(0, 99) < 25);
         bra_cmd   = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 7) == 0) tgt_cmd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else tgt_cmd = $urandom();
         cycle();
      end
      stall_cmd = 1'b0; bra_cmd = 1'b0;
      for (int i = 0; i < 20; i++) cycle();
      check("random_progress", consumed - base > 1000, 32'(consumed - base), 32'd1000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
